// File: rtl/mmx_counter_ctrl.sv
// Command-driven sequencer for the count datapath: start/stop/clear/load commands,
// power-of-two prescaler, terminal-count compare and the datapath enable/clear strobes.

module mmx_counter_ctrl #(
  parameter int WIDTH = 7,
  parameter int PRE_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  input  logic [3:0]       cmd_data,
  input  logic [WIDTH-1:0] cnt_val,
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   tc_q, tc_d;
  logic [1:0]         sel_q, sel_d;
  logic               reload_q, reload_d;
  logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
  logic               clr_pend_q, clr_pend_d;
  logic               done_q, done_d;

  logic [PRE_W-1:0]   div_m1_s;
  logic               tick_s;
  logic               term_s;
  logic [WIDTH+3:0]   tc_shift_s;

  // Prescaler terminal value (divisor minus one) for the selected power of two.
  always_comb begin
    case (sel_q)
      2'd0:    div_m1_s = PRE_W'(4'd0);
      2'd1:    div_m1_s = PRE_W'(4'd1);
      2'd2:    div_m1_s = PRE_W'(4'd3);
      2'd3:    div_m1_s = PRE_W'(4'd7);
      default: div_m1_s = PRE_W'(4'd0);
    endcase
  end

  assign tick_s     = (state_q == ST_RUN) && !clr_pend_q && (pre_cnt_q == div_m1_s);
  assign term_s     = tick_s && (cnt_val == tc_q);
  assign tc_shift_s = {tc_q, cmd_data};

  assign cnt_en  = tick_s && !term_s;
  assign cnt_clr = clr_pend_q || (term_s && reload_q);
  assign done    = done_q;
  assign state   = state_q;

  // Next-state logic: prescaler, terminal handling, then command decode.
  always_comb begin
    state_d    = state_q;
    tc_d       = tc_q;
    sel_d      = sel_q;
    reload_d   = reload_q;
    pre_cnt_d  = pre_cnt_q;
    clr_pend_d = 1'b0;
    done_d     = term_s;

    if (tick_s) begin
      pre_cnt_d = {PRE_W{1'b0}};
    end else if ((state_q == ST_RUN) && !clr_pend_q) begin
      pre_cnt_d = pre_cnt_q + PRE_W'(1'b1);
    end else begin
      pre_cnt_d = pre_cnt_q;
    end

    // A one-shot terminal event wins over a STOP arriving in the same cycle.
    if (term_s && !reload_q) begin
      state_d = ST_DONE;
    end else begin
      state_d = state_q;
    end

    if (cmd_valid) begin
      case (cmd_op)
        OP_START: begin
          if ((state_q == ST_IDLE) || (state_q == ST_DONE)) begin
            sel_d      = cmd_data[1:0];
            reload_d   = cmd_data[2];
            clr_pend_d = 1'b1;
            pre_cnt_d  = {PRE_W{1'b0}};
            state_d    = ST_RUN;
          end else if (state_q == ST_PAUSE) begin
            state_d = ST_RUN;
          end else begin
            state_d = state_d;
          end
        end
        OP_STOP: begin
          if ((state_q == ST_RUN) && !(term_s && !reload_q)) begin
            state_d = ST_PAUSE;
          end else begin
            state_d = state_d;
          end
        end
        OP_CLEAR: begin
          clr_pend_d = 1'b1;
          pre_cnt_d  = {PRE_W{1'b0}};
          state_d    = ST_IDLE;
        end
        OP_LOAD: begin
          if (state_q != ST_RUN) begin
            tc_d = tc_shift_s[WIDTH-1:0];
          end else begin
            tc_d = tc_q;
          end
        end
        default: begin
          state_d = state_d;
        end
      endcase
    end else begin
      state_d = state_d;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tc_q       <= {WIDTH{1'b1}};
      sel_q      <= 2'b00;
      reload_q   <= 1'b0;
      pre_cnt_q  <= {PRE_W{1'b0}};
      clr_pend_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tc_q       <= tc_d;
      sel_q      <= sel_d;
      reload_q   <= reload_d;
      pre_cnt_q  <= pre_cnt_d;
      clr_pend_q <= clr_pend_d;
      done_q     <= done_d;
    end
  end

  mmx_counter_ctrl_chk u_chk (
    .clk     (clk),
    .reset   (reset),
    .cnt_en  (cnt_en),
    .cnt_clr (cnt_clr),
    .state   (state)
  );

endmodule

// Protocol properties of the datapath strobes.
module mmx_counter_ctrl_chk (
  input logic       clk,
  input logic       reset,
  input logic       cnt_en,
  input logic       cnt_clr,
  input logic [1:0] state
);

  a_en_clr_excl: assert property (@(posedge clk) disable iff (reset) !(cnt_en && cnt_clr));
  a_en_in_run:   assert property (@(posedge clk) disable iff (reset) cnt_en |-> (state == 2'b01));

endmodule
